// File: rtl/pan_sequencer.sv
// Pan position sequencer: walks a programmable {pos, dwell} table, advancing on
// accepted audio samples, and drives the registered pan code to the panning datapath.
module pan_sequencer #(
  parameter int unsigned         NUM_STEPS     = 4,
  parameter int unsigned         IDX_W         = 2,
  parameter int unsigned         DWELL_W       = 16,
  parameter logic [1:0]          DEFAULT_POS   = 2'd1,
  parameter logic [DWELL_W-1:0]  DEFAULT_DWELL = DWELL_W'(4800)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_loop_mode,
  input  logic [IDX_W-1:0]   i_last_step,
  input  logic               i_sample_tick,
  input  logic               i_cfg_wr,
  input  logic [IDX_W-1:0]   i_cfg_addr,
  input  logic [1:0]         i_cfg_pos,
  input  logic [DWELL_W-1:0] i_cfg_dwell,
  output logic [1:0]         o_pan_pos,
  output logic [IDX_W-1:0]   o_step_idx,
  output logic               o_step_done,
  output logic               o_busy,
  output logic               o_seq_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t             r_state;
  logic [1:0]         r_tab_pos   [NUM_STEPS];
  logic [DWELL_W-1:0] r_tab_dwell [NUM_STEPS];
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;

  logic [DWELL_W-1:0] w_dwell_m1;
  logic               w_boundary;
  logic               w_at_last;
  logic [IDX_W-1:0]   w_next_idx;

  // Reads below see the pre-write table, so a same-cycle reload uses the old entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tab_pos[i]   <= DEFAULT_POS;
        r_tab_dwell[i] <= DEFAULT_DWELL;
      end
    end else if (i_cfg_wr) begin
      r_tab_pos[i_cfg_addr]   <= i_cfg_pos;
      r_tab_dwell[i_cfg_addr] <= i_cfg_dwell;
    end
  end

  // A dwell of zero behaves as one: every tick is a boundary.
  assign w_dwell_m1 = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
  assign w_boundary = i_sample_tick && (r_cnt == w_dwell_m1);
  assign w_at_last  = (o_step_idx >= i_last_step);
  assign w_next_idx = w_at_last ? '0 : o_step_idx + IDX_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_dwell     <= '0;
      r_cnt       <= '0;
      o_pan_pos   <= DEFAULT_POS;
      o_step_idx  <= '0;
      o_step_done <= 1'b0;
      o_busy      <= 1'b0;
      o_seq_done  <= 1'b0;
    end else begin
      o_step_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          o_pan_pos <= DEFAULT_POS;
          if (i_enable) begin
            r_state    <= StRun;
            o_busy     <= 1'b1;
            o_pan_pos  <= r_tab_pos[0];
            r_dwell    <= r_tab_dwell[0];
            r_cnt      <= '0;
            o_step_idx <= '0;
          end
        end
        StRun: begin
          if (!i_enable) begin
            r_state    <= StIdle;
            o_busy     <= 1'b0;
            o_pan_pos  <= DEFAULT_POS;
            r_cnt      <= '0;
            o_step_idx <= '0;
          end else if (w_boundary) begin
            o_step_done <= 1'b1;
            if (w_at_last && !i_loop_mode) begin
              r_state    <= StDone;
              o_busy     <= 1'b0;
              o_seq_done <= 1'b1;
            end else begin
              o_step_idx <= w_next_idx;
              o_pan_pos  <= r_tab_pos[w_next_idx];
              r_dwell    <= r_tab_dwell[w_next_idx];
              r_cnt      <= '0;
            end
          end else if (i_sample_tick && !(&r_cnt)) begin
            r_cnt <= r_cnt + DWELL_W'(1);
          end
        end
        StDone: begin
          if (!i_enable) begin
            r_state    <= StIdle;
            o_seq_done <= 1'b0;
            o_pan_pos  <= DEFAULT_POS;
            r_cnt      <= '0;
            o_step_idx <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pan_sequencer.sv
// Directed self-checking bench for pan_sequencer.
module tb_pan_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_loop_mode;
  logic [1:0]  i_last_step;
  logic        i_sample_tick;
  logic        i_cfg_wr;
  logic [1:0]  i_cfg_addr;
  logic [1:0]  i_cfg_pos;
  logic [15:0] i_cfg_dwell;
  logic [1:0]  o_pan_pos;
  logic [1:0]  o_step_idx;
  logic        o_step_done;
  logic        o_busy;
  logic        o_seq_done;

  int checks = 0;
  int errors = 0;

  pan_sequencer dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_loop_mode  (i_loop_mode),
    .i_last_step  (i_last_step),
    .i_sample_tick(i_sample_tick),
    .i_cfg_wr     (i_cfg_wr),
    .i_cfg_addr   (i_cfg_addr),
    .i_cfg_pos    (i_cfg_pos),
    .i_cfg_dwell  (i_cfg_dwell),
    .o_pan_pos    (o_pan_pos),
    .o_step_idx   (o_step_idx),
    .o_step_done  (o_step_done),
    .o_busy       (o_busy),
    .o_seq_done   (o_seq_done)
  );

  always #5 i_clk = ~i_clk;

  // One clock with the given tick level; returns 1 time unit after the edge.
  task automatic clk_step(input logic tick);
    i_sample_tick = tick;
    @(posedge i_clk);
    #1;
    i_sample_tick = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [1:0] pos,
                           input logic [15:0] dwell);
    i_cfg_wr = 1'b1; i_cfg_addr = addr; i_cfg_pos = pos; i_cfg_dwell = dwell;
    clk_step(1'b0);
    i_cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_pan_pos !== 2'd1 || o_step_idx !== 2'd0 || o_busy !== 1'b0 ||
        o_seq_done !== 1'b0 || o_step_done !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got pan=%0d idx=%0d busy=%0d sd=%0d done=%0d, required 1 0 0 0 0",
               o_pan_pos, o_step_idx, o_busy, o_seq_done, o_step_done);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_loop();
    logic [1:0] exp_pan  [10] = '{0, 0, 2, 2, 0, 0, 0, 2, 2, 0};
    logic       exp_done [10] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    cfg_write(2'd0, 2'd0, 16'd3);
    cfg_write(2'd1, 2'd2, 16'd2);
    i_last_step = 2'd1; i_loop_mode = 1'b1; i_enable = 1'b1;
    clk_step(1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_pan_pos !== 2'd0) begin
      errors++;
      $display("FAIL loop start: got busy=%0d pan=%0d, required 1 0", o_busy, o_pan_pos);
    end
    for (int k = 0; k < 10; k++) begin
      clk_step(1'b1);
      checks++;
      if (o_pan_pos !== exp_pan[k] || o_step_done !== exp_done[k]) begin
        errors++;
        $display("FAIL loop tick %0d: got pan=%0d step_done=%0d, required pan=%0d step_done=%0d",
                 k + 1, o_pan_pos, o_step_done, exp_pan[k], exp_done[k]);
      end
      for (int j = 0; j < 3; j++) clk_step(1'b0);
    end
    i_enable = 1'b0;
    clk_step(1'b0);
    checks++;
    if (o_pan_pos !== 2'd1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL loop disable: got pan=%0d busy=%0d, required 1 0", o_pan_pos, o_busy);
    end
  endtask

  task automatic test_oneshot();
    i_loop_mode = 1'b0; i_enable = 1'b1;
    clk_step(1'b0);
    for (int k = 0; k < 5; k++) begin
      clk_step(1'b1);
      clk_step(1'b0);
    end
    checks++;
    if (o_seq_done !== 1'b1 || o_pan_pos !== 2'd2 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot done: got sd=%0d pan=%0d busy=%0d, required 1 2 0",
               o_seq_done, o_pan_pos, o_busy);
    end
    for (int k = 0; k < 3; k++) begin
      clk_step(1'b1);
      checks++;
      if (o_seq_done !== 1'b1 || o_pan_pos !== 2'd2 || o_step_done !== 1'b0 ||
          o_step_idx !== 2'd1) begin
        errors++;
        $display("FAIL oneshot hold: got sd=%0d pan=%0d step_done=%0d idx=%0d, required 1 2 0 1",
                 o_seq_done, o_pan_pos, o_step_done, o_step_idx);
      end
    end
    i_enable = 1'b0;
    clk_step(1'b0);
    checks++;
    if (o_pan_pos !== 2'd1 || o_seq_done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot idle: got pan=%0d sd=%0d, required 1 0", o_pan_pos, o_seq_done);
    end
  endtask

  task automatic test_abort();
    i_loop_mode = 1'b1; i_enable = 1'b1;
    clk_step(1'b0);
    clk_step(1'b1);
    clk_step(1'b1);
    i_enable = 1'b0;
    clk_step(1'b1);  // boundary tick coincides with abort
    checks++;
    if (o_busy !== 1'b0 || o_pan_pos !== 2'd1 || o_step_done !== 1'b0 || o_step_idx !== 2'd0) begin
      errors++;
      $display("FAIL abort collision: got busy=%0d pan=%0d step_done=%0d idx=%0d, required 0 1 0 0",
               o_busy, o_pan_pos, o_step_done, o_step_idx);
    end
  endtask

  task automatic test_reconfig();
    i_enable = 1'b1;
    clk_step(1'b0);
    clk_step(1'b1);
    cfg_write(2'd0, 2'd3, 16'd5);
    clk_step(1'b1);
    checks++;
    if (o_pan_pos !== 2'd0 || o_step_idx !== 2'd0) begin
      errors++;
      $display("FAIL reconfig running step: got pan=%0d idx=%0d, required 0 0", o_pan_pos, o_step_idx);
    end
    clk_step(1'b1);
    checks++;
    if (o_pan_pos !== 2'd2 || o_step_idx !== 2'd1 || o_step_done !== 1'b1) begin
      errors++;
      $display("FAIL reconfig old dwell: got pan=%0d idx=%0d step_done=%0d, required 2 1 1",
               o_pan_pos, o_step_idx, o_step_done);
    end
    clk_step(1'b1);
    clk_step(1'b1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_pan_pos !== 2'd3) begin
        errors++;
        $display("FAIL reconfig new entry before tick %0d: got pan=%0d, required 3", k + 1, o_pan_pos);
      end
      clk_step(1'b1);
    end
    checks++;
    if (o_pan_pos !== 2'd2 || o_step_idx !== 2'd1) begin
      errors++;
      $display("FAIL reconfig new dwell: got pan=%0d idx=%0d, required 2 1", o_pan_pos, o_step_idx);
    end
    // Write entry 0 on the same edge that reloads it: reload sees the old value.
    clk_step(1'b1);
    i_cfg_wr = 1'b1; i_cfg_addr = 2'd0; i_cfg_pos = 2'd1; i_cfg_dwell = 16'd7;
    clk_step(1'b1);
    i_cfg_wr = 1'b0;
    checks++;
    if (o_pan_pos !== 2'd3 || o_step_idx !== 2'd0) begin
      errors++;
      $display("FAIL reload collision: got pan=%0d idx=%0d, required 3 0", o_pan_pos, o_step_idx);
    end
    for (int k = 0; k < 5; k++) clk_step(1'b1);
    clk_step(1'b1);
    clk_step(1'b1);
    checks++;
    if (o_pan_pos !== 2'd1 || o_step_idx !== 2'd0) begin
      errors++;
      $display("FAIL reload collision new value: got pan=%0d idx=%0d, required 1 0",
               o_pan_pos, o_step_idx);
    end
    i_enable = 1'b0;
    clk_step(1'b0);
  endtask

  task automatic test_dwell0();
    logic [1:0] exp_idx [4] = '{1, 0, 1, 0};
    logic [1:0] exp_pan [4] = '{3, 0, 3, 0};
    cfg_write(2'd0, 2'd0, 16'd0);
    cfg_write(2'd1, 2'd3, 16'd0);
    i_last_step = 2'd1; i_loop_mode = 1'b1; i_enable = 1'b1;
    clk_step(1'b0);
    for (int k = 0; k < 4; k++) begin
      clk_step(1'b1);
      checks++;
      if (o_step_idx !== exp_idx[k] || o_pan_pos !== exp_pan[k] || o_step_done !== 1'b1) begin
        errors++;
        $display("FAIL dwell0 clk %0d: got idx=%0d pan=%0d step_done=%0d, required %0d %0d 1",
                 k + 1, o_step_idx, o_pan_pos, o_step_done, exp_idx[k], exp_pan[k]);
      end
    end
    i_enable = 1'b0;
    clk_step(1'b0);
  endtask

  task automatic test_reset_mid_run();
    cfg_write(2'd0, 2'd0, 16'd1);
    cfg_write(2'd1, 2'd2, 16'd1);
    cfg_write(2'd2, 2'd3, 16'd1);
    i_last_step = 2'd3; i_loop_mode = 1'b1; i_enable = 1'b1;
    clk_step(1'b0);
    clk_step(1'b1);
    clk_step(1'b1);
    checks++;
    if (o_step_idx !== 2'd2 || o_pan_pos !== 2'd3) begin
      errors++;
      $display("FAIL pre-reset step 2: got idx=%0d pan=%0d, required 2 3", o_step_idx, o_pan_pos);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_pan_pos !== 2'd1 || o_busy !== 1'b0 || o_step_idx !== 2'd0) begin
      errors++;
      $display("FAIL async reset mid-run: got pan=%0d busy=%0d idx=%0d, required 1 0 0",
               o_pan_pos, o_busy, o_step_idx);
    end
    #2;
    i_rst_n = 1'b1;
    clk_step(1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_pan_pos !== 2'd1) begin
      errors++;
      $display("FAIL default entry 0 pos: got busy=%0d pan=%0d, required 1 1", o_busy, o_pan_pos);
    end
    for (int k = 0; k < 4799; k++) clk_step(1'b1);
    checks++;
    if (o_step_idx !== 2'd0 || o_step_done !== 1'b0) begin
      errors++;
      $display("FAIL default dwell early: got idx=%0d step_done=%0d, required 0 0", o_step_idx, o_step_done);
    end
    clk_step(1'b1);
    checks++;
    if (o_step_idx !== 2'd1 || o_step_done !== 1'b1 || o_pan_pos !== 2'd1) begin
      errors++;
      $display("FAIL default dwell boundary: got idx=%0d step_done=%0d pan=%0d, required 1 1 1",
               o_step_idx, o_step_done, o_pan_pos);
    end
    i_enable = 1'b0;
    clk_step(1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b0; i_loop_mode = 1'b0; i_last_step = 2'd0;
    i_sample_tick = 1'b0; i_cfg_wr = 1'b0; i_cfg_addr = 2'd0; i_cfg_pos = 2'd0;
    i_cfg_dwell = 16'd0;
    @(posedge i_clk); #1;
    test_reset();
    test_loop();
    test_oneshot();
    test_abort();
    test_reconfig();
    test_dwell0();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
